// File: rtl/rs232_rx_fifo_if.sv
// Bundle between the RS-232 receiver/CPU side and the receive FIFO.
// master: receiver + CPU strobes; slave: the FIFO itself.
interface rs232_rx_fifo_if #(
    parameter int unsigned AW = 4
) ();
    logic [7:0]  rxdata;
    logic        rxrdy;
    logic        rxdone;
    logic        pop;
    logic        clrovr;
    logic [7:0]  dout;
    logic        nonempty;
    logic [AW:0] count;
    logic        overrun;

    modport master (
        output rxdata, rxrdy, pop, clrovr,
        input  rxdone, dout, nonempty, count, overrun
    );

    modport slave (
        input  rxdata, rxrdy, pop, clrovr,
        output rxdone, dout, nonempty, count, overrun
    );
endinterface

// File: rtl/rs232_rx_fifo.sv
// Receive FIFO between the RS-232 receiver and the CPU I/O read mux.
// Circular buffer of 2^AW bytes, first-word-fall-through output, sticky overrun.
module rs232_rx_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rs232_rx_fifo_if.slave       io_bus
);
    localparam int unsigned Depth = 1 << AW;
    localparam logic [AW:0] FullCount = Depth[AW:0];

    logic [7:0]    r_mem [Depth];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_rxdone;
    logic          r_overrun;

    logic w_take;
    logic w_nonempty;
    logic w_full;
    logic w_pop;
    logic w_store;
    logic w_discard;

    // ~rxdone stops a second take while the receiver still shows rdy in the ack cycle
    assign w_take     = io_bus.rxrdy & ~r_rxdone;
    assign w_nonempty = (r_count != '0);
    // count is one bit wider than the pointers so full is unambiguous
    assign w_full     = (r_count == FullCount);
    assign w_pop      = io_bus.pop & w_nonempty;
    // a pop in the same cycle frees a slot for a take when full
    assign w_store    = w_take & (~w_full | w_pop);
    assign w_discard  = w_take & ~w_store;

    // Storage write; contents need no reset
    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= io_bus.rxdata;
        end
    end

    // Pointers, occupancy, handshake ack and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rxdone  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rxdone <= w_take;
            if (w_store) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_store && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // a discard in the same cycle as clrovr keeps the flag set
            if (w_discard) begin
                r_overrun <= 1'b1;
            end else if (io_bus.clrovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Output decode: oldest byte when non-empty, zero otherwise
    always_comb begin
        io_bus.dout     = w_nonempty ? r_mem[r_rptr] : 8'h00;
        io_bus.nonempty = w_nonempty;
        io_bus.count    = r_count;
        io_bus.rxdone   = r_rxdone;
        io_bus.overrun  = r_overrun;
    end
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Bench for rs232_rx_fifo: directed scenarios then randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_rs232_rx_fifo;
    localparam int unsigned AW    = 4;
    localparam int unsigned Depth = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs232_rx_fifo_if #(.AW(AW)) bus ();

    rs232_rx_fifo #(.AW(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: byte queue, expected ack flag, sticky overrun flag
    byte unsigned m_q[$];
    bit           m_ack = 1'b0;
    bit           m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [7:0] exp_dout;
        exp_dout = (m_q.size() != 0) ? m_q[0] : 8'h00;
        chk("rxdone",   32'(bus.rxdone),   32'(m_ack));
        chk("nonempty", 32'(bus.nonempty), 32'(m_q.size() != 0));
        chk("count",    32'(bus.count),    32'(m_q.size()));
        chk("dout",     32'(bus.dout),     32'(exp_dout));
        chk("overrun",  32'(bus.overrun),  32'(m_ovr));
    endtask

    // One clock: apply pop/clrovr strobes, advance the model, check after the edge.
    // The receiver drops rxrdy on the edge that samples rxdone high.
    task automatic cycle(input bit p, input bit c);
        bit           take;
        bit           popped;
        bit           discard;
        bit           was_ack;
        byte unsigned tmp;
        bus.pop    = p;
        bus.clrovr = c;
        was_ack = m_ack;
        take    = bus.rxrdy && !m_ack;
        discard = take && (m_q.size() == Depth) && !p;
        popped  = p && (m_q.size() != 0);
        if (popped) tmp = m_q.pop_front();
        if (take && !discard) m_q.push_back(bus.rxdata);
        if (discard) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        m_ack = take;
        @(posedge clk);
        #1;
        bus.pop    = 1'b0;
        bus.clrovr = 1'b0;
        if (was_ack) bus.rxrdy = 1'b0;
        chk_all();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rxdata = b;
        bus.rxrdy  = 1'b1;
        for (int i = 0; i < 8 && bus.rxrdy; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 32'(bus.dout), 32'(exp));
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        bus.rxdata = 8'h00;
        bus.rxrdy  = 1'b0;
        bus.pop    = 1'b0;
        bus.clrovr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;
        #1;
        chk_all();

        // Single byte handshake: one-cycle ack, no double take
        bus.rxdata = 8'h41;
        bus.rxrdy  = 1'b1;
        cycle(1'b0, 1'b0);
        chk("t1_rxdone_hi", 32'(bus.rxdone), 32'd1);
        chk("t1_dout", 32'(bus.dout), 32'h41);
        cycle(1'b0, 1'b0);
        chk("t1_rxdone_lo", 32'(bus.rxdone), 32'd0);
        chk("t1_count", 32'(bus.count), 32'd1);
        pop_chk("t1_pop", 8'h41);

        // Fill, overflow discard, drain in order
        for (int i = 1; i <= 16; i++) send(8'(i));
        chk("t2_full", 32'(bus.count), 32'd16);
        send(8'hAA);
        chk("t2_ovr", 32'(bus.overrun), 32'd1);
        chk("t2_count", 32'(bus.count), 32'd16);
        for (int i = 1; i <= 16; i++) pop_chk("t2_order", 8'(i));
        chk("t2_empty", 32'(bus.nonempty), 32'd0);
        chk("t2_dout0", 32'(bus.dout), 32'd0);
        cycle(1'b0, 1'b1);
        chk("t2_clr", 32'(bus.overrun), 32'd0);

        // Full with simultaneous pop: take is stored
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
        bus.rxdata = 8'h55;
        bus.rxrdy  = 1'b1;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t3_count", 32'(bus.count), 32'd16);
        chk("t3_ovr", 32'(bus.overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("t3_order", 8'(8'h20 + i));
        pop_chk("t3_last", 8'h55);

        // Pointer wrap
        for (int i = 0; i < 10; i++) send(8'(8'h60 + i));
        for (int i = 0; i < 10; i++) pop_chk("t4_a", 8'(8'h60 + i));
        for (int i = 0; i < 10; i++) send(8'(8'hC0 + i));
        for (int i = 0; i < 10; i++) pop_chk("t4_b", 8'(8'hC0 + i));
        chk("t4_count", 32'(bus.count), 32'd0);

        // Pop while empty is ignored
        repeat (3) cycle(1'b1, 1'b0);
        chk("t5_count", 32'(bus.count), 32'd0);
        send(8'h7E);
        chk("t5_dout", 32'(bus.dout), 32'h7E);
        pop_chk("t5_pop", 8'h7E);

        // Overrun set wins over simultaneous clear
        for (int i = 0; i < 16; i++) send(8'(8'h90 + i));
        send(8'hCC);
        chk("t6_set", 32'(bus.overrun), 32'd1);
        bus.rxdata = 8'hBB;
        bus.rxrdy  = 1'b1;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t6_setwins", 32'(bus.overrun), 32'd1);
        cycle(1'b0, 1'b1);
        chk("t6_clr", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 16; i++) pop_chk("t6_drain", 8'(8'h90 + i));

        // Asynchronous reset mid-burst, with an ack outstanding
        for (int i = 0; i < 4; i++) send(8'(8'h30 + i));
        bus.rxdata = 8'h5A;
        bus.rxrdy  = 1'b1;
        cycle(1'b0, 1'b0);
        chk("t7_pre_count", 32'(bus.count), 32'd5);
        chk("t7_pre_done", 32'(bus.rxdone), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_count", 32'(bus.count), 32'd0);
        chk("t7_async_ne", 32'(bus.nonempty), 32'd0);
        chk("t7_async_done", 32'(bus.rxdone), 32'd0);
        m_q.delete();
        m_ack = 1'b0;
        m_ovr = 1'b0;
        bus.rxdata = 8'h99;
        @(posedge clk);
        #1;
        chk("t7_held_count", 32'(bus.count), 32'd0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("t7_after", 32'(bus.dout), 32'h99);
        pop_chk("t7_pop", 8'h99);

        // Randomized traffic at three pop rates (low rate drives into overflow)
        for (int ph = 0; ph < 3; ph++) begin
            int pop_pct;
            pop_pct = (ph == 0) ? 10 : ((ph == 1) ? 50 : 90);
            for (int n = 0; n < 600; n++) begin
                bit p;
                bit c;
                if (!bus.rxrdy && $urandom_range(0, 99) < 60) begin
                    bus.rxdata = 8'($urandom);
                    bus.rxrdy  = 1'b1;
                end
                p = ($urandom_range(0, 99) < pop_pct);
                c = ($urandom_range(0, 99) < 3);
                cycle(p, c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
